// File: rtl/riscv_pkg.sv
// Shared datapath widths, ALU control codes and stage state encoding
// for the in-order pipeline.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_LESS = 3'b111;

  localparam logic [2:0] ALU_CTRL_RST = ALU_ADD;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Operand forwarding priority mux: register 0 reads zero, the EX/MEM result
// wins over the MEM/WB result, otherwise the supplied value passes through.
import riscv_pkg::*;

module operand_fwd_mux (
  input  logic [RA_W-1:0] idx,
  input  logic [XLEN-1:0] val,
  input  logic            mem_wen,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_wen,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = val;
    if (idx == '0) begin
      result = '0;
    end else if (mem_wen && (mem_rd == idx)) begin
      result = mem_data;
    end else if (wb_wen && (wb_rd == idx)) begin
      result = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake and operand forwarding
// from the EX/MEM and MEM/WB result buses.
import riscv_pkg::*;

module id_ex_stage (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rs,
  input  logic [RA_W-1:0] in_rt,
  input  logic [RA_W-1:0] in_rd,
  input  logic [XLEN-1:0] in_rdata1,
  input  logic [XLEN-1:0] in_rdata2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alu_src,
  input  logic [2:0]      in_alu_op,
  input  logic            in_reg_write,
  input  logic            mem_fwd_wen,
  input  logic [RA_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_wen,
  input  logic [RA_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  output logic [2:0]      ALUControl,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write
);

  stage_state_t state, state_n;

  logic [RA_W-1:0] rs, rt, rd;
  logic [XLEN-1:0] op1, op2, imm;
  logic            alu_src;
  logic [2:0]      alu_op;
  logic            reg_write;

  logic            accept;
  logic            hold;
  logic [XLEN-1:0] acc_op1, acc_op2;
  logic [XLEN-1:0] st_op1, st_op2;

  assign in_ready = (state == ST_EMPTY) || ex_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign hold     = (state == ST_FULL) && !ex_ready && !flush;

  // Accept path: catch a result landing in the same cycle as the register read.
  operand_fwd_mux u_fwd_acc_rs (
    .idx(in_rs), .val(in_rdata1),
    .mem_wen(mem_fwd_wen), .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
    .wb_wen(wb_fwd_wen), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .result(acc_op1)
  );

  operand_fwd_mux u_fwd_acc_rt (
    .idx(in_rt), .val(in_rdata2),
    .mem_wen(mem_fwd_wen), .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
    .wb_wen(wb_fwd_wen), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .result(acc_op2)
  );

  // Stored path: drives the ALU and refreshes held operands during a stall.
  operand_fwd_mux u_fwd_st_rs (
    .idx(rs), .val(op1),
    .mem_wen(mem_fwd_wen), .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
    .wb_wen(wb_fwd_wen), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .result(st_op1)
  );

  operand_fwd_mux u_fwd_st_rt (
    .idx(rt), .val(op2),
    .mem_wen(mem_fwd_wen), .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
    .wb_wen(wb_fwd_wen), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .result(st_op2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = ST_EMPTY;
    end else if (accept) begin
      state_n = ST_FULL;
    end else if ((state == ST_FULL) && ex_ready) begin
      state_n = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs        <= '0;
      rt        <= '0;
      rd        <= '0;
      op1       <= '0;
      op2       <= '0;
      imm       <= '0;
      alu_src   <= 1'b0;
      alu_op    <= ALU_CTRL_RST;
      reg_write <= 1'b0;
    end else if (accept) begin
      rs        <= in_rs;
      rt        <= in_rt;
      rd        <= in_rd;
      op1       <= acc_op1;
      op2       <= acc_op2;
      imm       <= in_imm;
      alu_src   <= in_alu_src;
      alu_op    <= in_alu_op;
      reg_write <= in_reg_write;
    end else if (hold) begin
      op1 <= st_op1;
      op2 <= st_op2;
    end
  end

  assign ex_valid     = (state == ST_FULL);
  assign ex_reg_write = ex_valid && reg_write;
  assign ex_rd        = rd;
  assign ALUControl   = alu_op;
  assign data1        = st_op1;
  assign data2        = alu_src ? imm : st_op2;

endmodule
